prng_uniform_sampler: RTL and testbench

PRNG_UNIFORM_SAMPLER -- requirements
Module: prng_uniform_sampler

---
 rtl/fhe_prng_pkg.sv | 19 +
 rtl/prng_chunk_select.sv | 28 ++
 rtl/prng_uniform_sampler.sv | 116 +++++++++++
 tb/tb_prng_uniform_sampler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fhe_prng_pkg.sv
// Shared constants and state encoding for the PRNG uniform sampler.
// Q/N/CW define the target ring; a 512-bit block yields 36 chunks.
package fhe_prng_pkg;

  localparam int Q      = 12289;
  localparam int N      = 256;
  localparam int CW     = 14;
  localparam int NCHUNK = 36;
  localparam int BLK_W  = 512;
  localparam int PW     = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BLK,
    S_SCAN,
    S_DONE
  } state_t;

endpackage

// File: rtl/prng_chunk_select.sv
// Picks chunk ptr out of the block buffer and flags it when below Q.
// Bits above the last whole chunk are never selected.
module prng_chunk_select
  import fhe_prng_pkg::*;
#(
  parameter int P_Q  = fhe_prng_pkg::Q,
  parameter int P_CW = fhe_prng_pkg::CW
) (
  input  logic [BLK_W-1:0] buffer,
  input  logic [PW-1:0]    ptr,
  output logic [P_CW-1:0]  chunk,
  output logic             accept
);

  logic w_unused_tail;

  assign w_unused_tail = ^buffer[BLK_W-1:NCHUNK*P_CW];

  always_comb begin
    chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (ptr == PW'(k)) chunk = buffer[P_CW*k +: P_CW];
    end
  end

  assign accept = 32'(chunk) < 32'(P_Q);

endmodule

// File: rtl/prng_uniform_sampler.sv
// Rejection sampler: turns 512-bit PRNG blocks into N coefficients
// uniform in [0, Q), streamed out over a valid/ready handshake.
module prng_uniform_sampler
  import fhe_prng_pkg::*;
#(
  parameter int Q  = fhe_prng_pkg::Q,
  parameter int N  = fhe_prng_pkg::N,
  parameter int CW = fhe_prng_pkg::CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BLK_W-1:0] prng_data,
  input  logic             prng_valid,
  output logic             prng_ready,
  output logic [CW-1:0]    coeff,
  output logic [7:0]       coeff_idx,
  output logic             coeff_valid,
  input  logic             coeff_ready,
  output logic             poly_done,
  output logic             busy,
  output logic [15:0]      reject_cnt
);

  state_t           r_state;
  state_t           w_next;
  logic [BLK_W-1:0] r_buf;
  logic [PW-1:0]    r_ptr;
  logic [7:0]       r_idx;
  logic [15:0]      r_cnt;
  logic [15:0]      r_rej;

  logic [CW-1:0]    w_chunk;
  logic             w_accept;
  logic             w_last_chunk;
  logic             w_last_coef;

  prng_chunk_select #(
    .P_Q  (Q),
    .P_CW (CW)
  ) u_sel (
    .buffer (r_buf),
    .ptr    (r_ptr),
    .chunk  (w_chunk),
    .accept (w_accept)
  );

  assign w_last_chunk = r_ptr == PW'(NCHUNK - 1);
  assign w_last_coef  = r_cnt == 16'(N - 1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (start) w_next = S_WAIT_BLK;
      S_WAIT_BLK: if (prng_valid) w_next = S_SCAN;
      S_SCAN: begin
        if (!w_accept) begin
          if (w_last_chunk) w_next = S_WAIT_BLK;
        end else if (coeff_ready) begin
          if (w_last_coef)       w_next = S_DONE;
          else if (w_last_chunk) w_next = S_WAIT_BLK;
        end
      end
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_rej   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx <= '0;
            r_cnt <= '0;
            r_rej <= '0;
          end
        end
        S_WAIT_BLK: begin
          if (prng_valid) begin
            r_buf <= prng_data;
            r_ptr <= '0;
          end
        end
        S_SCAN: begin
          if (!w_accept) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_rej != 16'hFFFF) r_rej <= r_rej + 1'b1;
          end else if (coeff_ready) begin
            r_ptr <= r_ptr + 1'b1;
            r_idx <= r_idx + 1'b1;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign prng_ready  = r_state == S_WAIT_BLK;
  assign coeff_valid = (r_state == S_SCAN) && w_accept;
  assign coeff       = coeff_valid ? w_chunk : '0;
  assign coeff_idx   = r_idx;
  assign poly_done   = r_state == S_DONE;
  assign busy        = r_state != S_IDLE;
  assign reject_cnt  = r_rej;

endmodule

// File: tb/tb_prng_uniform_sampler.sv
// Directed bench for prng_uniform_sampler with hand-computed vectors.
// Covers acceptance, rejection, stalls, block refills, done and reset.
module tb_prng_uniform_sampler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] prng_data;
  logic         prng_valid;
  logic         prng_ready;
  logic [13:0]  coeff;
  logic [7:0]   coeff_idx;
  logic         coeff_valid;
  logic         coeff_ready;
  logic         poly_done;
  logic         busy;
  logic [15:0]  reject_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  prng_uniform_sampler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .prng_data   (prng_data),
    .prng_valid  (prng_valid),
    .prng_ready  (prng_ready),
    .coeff       (coeff),
    .coeff_idx   (coeff_idx),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .poly_done   (poly_done),
    .busy        (busy),
    .reject_cnt  (reject_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] fill(input logic [13:0] v);
    logic [511:0] b;
    b = '1;
    for (int k = 0; k < 36; k++) b[14*k +: 14] = v;
    return b;
  endfunction

  function automatic logic [511:0] ramp(input int blk);
    logic [511:0] b;
    b = '1;
    for (int k = 0; k < 36; k++) b[14*k +: 14] = 14'(blk*36 + k);
    return b;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (prng_ready) break;
      tick();
    end
    chk("prng_ready_wait", int'(prng_ready), 1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic give_blk(input logic [511:0] b);
    wait_ready();
    prng_data  = b;
    prng_valid = 1'b1;
    tick();
    prng_valid = 1'b0;
  endtask

  task automatic stream(input int total);
    int got;
    int blk;
    got = 0;
    blk = 0;
    coeff_ready = 1'b1;
    while (got < total) begin
      give_blk(ramp(blk));
      for (int k = 0; k < 36 && got < total; k++) begin
        chk("st_valid", int'(coeff_valid), 1);
        chk("st_coeff", int'(coeff), blk*36 + k);
        chk("st_idx", int'(coeff_idx), got % 256);
        chk("st_done", int'(poly_done), 0);
        tick();
        got++;
      end
      blk++;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_prdy"}, int'(prng_ready), 0);
    chk({tag, "_coeff"}, int'(coeff), 0);
    chk({tag, "_idx"}, int'(coeff_idx), 0);
    chk({tag, "_cval"}, int'(coeff_valid), 0);
    chk({tag, "_done"}, int'(poly_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_rej"}, int'(reject_cnt), 0);
  endtask

  initial begin
    logic [511:0] b;
    rst         = 1'b1;
    start       = 1'b0;
    prng_data   = '0;
    prng_valid  = 1'b0;
    coeff_ready = 1'b0;
    tick();
    tick();
    chk_reset_outs("rst0");
    rst = 1'b0;
    tick();
    chk("idle_busy", int'(busy), 0);

    // all chunks 5: 36 back-to-back coefficients
    coeff_ready = 1'b1;
    do_start();
    chk("wb_ready", int'(prng_ready), 1);
    chk("wb_busy", int'(busy), 1);
    give_blk(fill(14'd5));
    for (int i = 0; i < 36; i++) begin
      chk("c5_valid", int'(coeff_valid), 1);
      chk("c5_coeff", int'(coeff), 5);
      chk("c5_idx", int'(coeff_idx), i);
      tick();
    end
    chk("c5_refill", int'(prng_ready), 1);
    chk("c5_rej", int'(reject_cnt), 0);

    // rejections, stall, ignored start and prng_valid
    reset_pulse();
    coeff_ready = 1'b0;
    do_start();
    b = fill(14'd1);
    b[13:0]  = 14'h3FFF;
    b[27:14] = 14'h3001;
    b[41:28] = 14'h3000;
    b[55:42] = 14'd7;
    give_blk(b);
    chk("rj0_valid", int'(coeff_valid), 0);
    chk("rj0_rej", int'(reject_cnt), 0);
    coeff_ready = 1'b1;
    tick();
    chk("rj1_valid", int'(coeff_valid), 0);
    chk("rj1_rej", int'(reject_cnt), 1);
    chk("rj1_idx", int'(coeff_idx), 0);
    tick();
    chk("acc_valid", int'(coeff_valid), 1);
    chk("acc_coeff", int'(coeff), 12288);
    chk("acc_idx", int'(coeff_idx), 0);
    chk("acc_rej", int'(reject_cnt), 2);
    coeff_ready = 1'b0;
    start       = 1'b1;
    prng_valid  = 1'b1;
    prng_data   = fill(14'd9);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", int'(coeff_valid), 1);
      chk("stall_coeff", int'(coeff), 12288);
      chk("stall_idx", int'(coeff_idx), 0);
      chk("stall_prdy", int'(prng_ready), 0);
      chk("stall_busy", int'(busy), 1);
    end
    start       = 1'b0;
    prng_valid  = 1'b0;
    coeff_ready = 1'b1;
    tick();
    chk("c3_coeff", int'(coeff), 7);
    chk("c3_idx", int'(coeff_idx), 1);
    for (int k = 4; k < 36; k++) begin
      tick();
      chk("tail_coeff", int'(coeff), 1);
      chk("tail_idx", int'(coeff_idx), k - 2);
    end
    tick();
    chk("rj_refill", int'(prng_ready), 1);
    chk("rj_final", int'(reject_cnt), 2);

    // full polynomial across 8 blocks
    reset_pulse();
    do_start();
    stream(256);
    chk("pd_pulse", int'(poly_done), 1);
    chk("pd_busy", int'(busy), 1);
    chk("pd_cval", int'(coeff_valid), 0);
    chk("pd_prdy", int'(prng_ready), 0);
    chk("pd_rej", int'(reject_cnt), 0);
    tick();
    chk("pd_low", int'(poly_done), 0);
    chk("pd_idle", int'(busy), 0);
    tick();
    chk("pd_once", int'(poly_done), 0);

    // reset mid-polynomial after 100 coefficients
    reset_pulse();
    do_start();
    stream(100);
    chk("mid_idx", int'(coeff_idx), 100);
    reset_pulse();
    chk_reset_outs("rst1");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_done", int'(poly_done), 0);
      chk("post_busy", int'(busy), 0);
      chk("post_prdy", int'(prng_ready), 0);
    end
    do_start();
    give_blk(fill(14'd3));
    chk("re_valid", int'(coeff_valid), 1);
    chk("re_coeff", int'(coeff), 3);
    chk("re_idx", int'(coeff_idx), 0);
    chk("re_rej", int'(reject_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
